sa_result_drain: RTL and testbench

Output-side drain for the systolic array core. It snapshots the per-row 32-bit accumulator results and valid flags the core presents, and acknowledges the core with a one-cycle outread pulse. It then serialises the captured rows, lowest row first, onto a single valid/ready stream for the downstream writeback path. It is the consumer end of the core's routport/rvalidport/outread result interface.

---
 rtl/sa_pkg.sv | 17 +
 rtl/sa_result_drain_if.sv | 28 ++
 rtl/sa_next_row.sv | 25 ++
 rtl/sa_result_drain.sv | 97 +++++++++
 tb/tb_sa_result_drain.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array result path.
package sa_pkg;

  localparam int SA_ROWS  = 8;
  localparam int SA_ACC_W = 32;
  localparam int SA_ROW_W = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1;

  typedef logic [SA_ROW_W-1:0] row_idx_t;
  typedef logic [SA_ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SEND
  } drain_state_t;

endpackage

// File: rtl/sa_result_drain_if.sv
// Core result capture and writeback stream bundle; master is the drain, slave the core/writeback side.
interface sa_result_drain_if #(
  parameter int ROWS  = 8,
  parameter int ACC_W = 32
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS-1:0]            rvalid_in;
  logic [ROWS-1:0][ACC_W-1:0] rdata_in;
  logic                       outread;
  logic                       m_valid;
  logic                       m_ready;
  logic [ACC_W-1:0]           m_data;
  logic [RW-1:0]              m_row;
  logic                       m_last;

  modport master (
    input  rvalid_in, rdata_in, m_ready,
    output outread, m_valid, m_data, m_row, m_last
  );

  modport slave (
    output rvalid_in, rdata_in, m_ready,
    input  outread, m_valid, m_data, m_row, m_last
  );

endinterface

// File: rtl/sa_next_row.sv
// Lowest-set-row finder over the remaining capture mask.
module sa_next_row
  import sa_pkg::*;
#(
  parameter  int ROWS = SA_ROWS,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS-1:0] mask_i,
  output logic [RW-1:0]   idx_o,
  output logic            none_o,
  output logic            one_o
);

  // Scanning downward leaves the lowest set row as the final assignment.
  always_comb begin
    idx_o = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = RW'(i);
    end
  end

  assign none_o = (mask_i == '0);
  assign one_o  = !none_o && ((mask_i & (mask_i - 1'b1)) == '0);

endmodule

// File: rtl/sa_result_drain.sv
// Snapshots the core's per-row results, acknowledges with outread, then streams valid rows lowest first.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter  int ROWS  = SA_ROWS,
  parameter  int ACC_W = SA_ACC_W,
  parameter  int CNT_W = 16,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  sa_result_drain_if.master   bus,
  output logic                busy,
  output logic [CNT_W-1:0]    snap_cnt
);

  drain_state_t               state_q, state_d;
  logic [ROWS-1:0]            mask_q, mask_d;
  logic [ROWS-1:0][ACC_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       outread_q;

  logic [RW-1:0] idx;
  logic          none;
  logic          one;
  logic          present;
  logic          accept;

  sa_next_row #(.ROWS(ROWS)) u_next_row (
    .mask_i (mask_q),
    .idx_o  (idx),
    .none_o (none),
    .one_o  (one)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_row   = '0;
    bus.m_last  = 1'b0;

    present = (state_q != IDLE) && !none;
    accept  = present && bus.m_ready;

    if (present) begin
      bus.m_valid = 1'b1;
      bus.m_data  = buf_q[idx];
      bus.m_row   = idx;
      bus.m_last  = one;
    end

    unique case (state_q)
      IDLE: begin
        if (|bus.rvalid_in) begin
          buf_d   = bus.rdata_in;
          mask_d  = bus.rvalid_in;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = SEND;
      SEND:    if (none) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The beat shown in ACK may already be taken, so acceptance is handled for both ACK and SEND.
    if (accept) begin
      mask_d[idx] = 1'b0;
      if (one) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      outread_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      outread_q <= (state_d == ACK);
    end
  end

  assign bus.outread = outread_q;
  assign busy        = (state_q != IDLE);
  assign snap_cnt    = cnt_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: table-driven snapshots plus reset, back-to-back and counter corner cases.
module tb_sa_result_drain;
  import sa_pkg::*;

  localparam int ROWS  = 8;
  localparam int ACC_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] snapCnt;
  logic        busyC;
  logic [1:0]  snapCntC;

  always #5 clk = ~clk;

  sa_result_drain_if #(.ROWS(ROWS), .ACC_W(ACC_W)) bus ();
  sa_result_drain_if #(.ROWS(ROWS), .ACC_W(ACC_W)) busC ();

  sa_result_drain #(.ROWS(ROWS), .ACC_W(ACC_W), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .snap_cnt (snapCnt)
  );

  sa_result_drain #(.ROWS(ROWS), .ACC_W(ACC_W), .CNT_W(2)) dutC (
    .clk      (clk),
    .rst      (rst),
    .bus      (busC),
    .busy     (busyC),
    .snap_cnt (snapCntC)
  );

  typedef struct {
    row_idx_t row;
    acc_t     data;
    logic     last;
  } beat_t;

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] base;
    int          pct;
    bit          junk;
    int          expBeats;
    int          expLastRow;
  } vec_t;

  beat_t    expQ[$];
  int       checks = 0;
  int       errors = 0;
  int       beatsSeen = 0;
  int       lastRowSeen = -1;
  int       outreadPulses = 0;
  int       snapExp = 0;
  logic     prevStall = 1'b0;
  logic     prevOutread = 1'b0;
  acc_t     heldData;
  row_idx_t heldRow;
  logic     heldLast;

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Stream monitor: pops the scoreboard on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prevStall   = 1'b0;
      prevOutread = 1'b0;
    end else begin
      if (bus.outread) begin
        checkVal("outreadTwice", {31'd0, prevOutread}, 32'd0);
        outreadPulses++;
      end
      prevOutread = bus.outread;
      if (prevStall) begin
        checkVal("stallValid", {31'd0, bus.m_valid}, 32'd1);
        checkVal("stallData", bus.m_data, heldData);
        checkVal("stallRow", {29'd0, bus.m_row}, {29'd0, heldRow});
        checkVal("stallLast", {31'd0, bus.m_last}, {31'd0, heldLast});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedBeat actual row=%0d data=0x%0h expected no beat", bus.m_row, bus.m_data);
        end else begin
          beat_t b;
          b = expQ.pop_front();
          checkVal("beatRow", {29'd0, bus.m_row}, {29'd0, b.row});
          checkVal("beatData", bus.m_data, b.data);
          checkVal("beatLast", {31'd0, bus.m_last}, {31'd0, b.last});
        end
        beatsSeen++;
        lastRowSeen = int'(bus.m_row);
      end
      prevStall = bus.m_valid && !bus.m_ready;
      heldData  = bus.m_data;
      heldRow   = bus.m_row;
      heldLast  = bus.m_last;
    end
  end

  task automatic pushExpected(input logic [7:0] mask, input logic [31:0] base);
    int    top;
    beat_t b;
    top = -1;
    for (int i = 0; i < ROWS; i++) if (mask[i]) top = i;
    for (int i = 0; i < ROWS; i++) begin
      if (mask[i]) begin
        b.row  = row_idx_t'(i);
        b.data = base + 32'(i);
        b.last = (i == top);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input logic [31:0] base, input int pct, input bit junk);
    int startPulses;
    int edges;
    bit done;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) bus.rdata_in[r] = base + 32'(r);
    bus.rvalid_in = mask;
    pushExpected(mask, base);
    startPulses = outreadPulses;
    snapExp++;
    @(posedge clk);
    #1;
    checkVal("outreadLatency", {31'd0, bus.outread}, 32'd1);
    checkVal("firstValid", {31'd0, bus.m_valid}, 32'd1);
    bus.rvalid_in = '0;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 200) begin
      bus.m_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < pct);
      if (junk) begin
        bus.rvalid_in = 8'($urandom);
        for (int r = 0; r < ROWS; r++) bus.rdata_in[r] = $urandom;
      end
      @(posedge clk);
      #1;
      edges++;
      if (!busy) done = 1'b1;
    end
    bus.rvalid_in = '0;
    checkVal("drainDone", {31'd0, done}, 32'd1);
    if (pct >= 100) checkVal("drainCycles", 32'(edges), 32'($countones(mask)));
    checkVal("queueEmpty", 32'(expQ.size()), 32'd0);
    checkVal("outreadOnce", 32'(outreadPulses - startPulses), 32'd1);
    checkVal("validAfterDrain", {31'd0, bus.m_valid}, 32'd0);
    checkVal("snapCnt", {16'd0, snapCnt}, 32'(snapExp));
  endtask

  vec_t vecs[6];
  int   expC[5];

  initial begin
    int startBeats;
    int n;

    bus.rvalid_in  = '0;
    bus.rdata_in   = '0;
    bus.m_ready    = 1'b0;
    busC.rvalid_in = '0;
    busC.rdata_in  = '0;
    busC.m_ready   = 1'b1;

    vecs[0] = '{mask: 8'hFF, base: 32'd100,   pct: 100, junk: 1'b0, expBeats: 8, expLastRow: 7};
    vecs[1] = '{mask: 8'hA4, base: 32'hA0,    pct: 100, junk: 1'b0, expBeats: 3, expLastRow: 7};
    vecs[2] = '{mask: 8'hFF, base: 32'd200,   pct: 50,  junk: 1'b1, expBeats: 8, expLastRow: 7};
    vecs[3] = '{mask: 8'h10, base: 32'd300,   pct: 100, junk: 1'b0, expBeats: 1, expLastRow: 4};
    vecs[4] = '{mask: 8'h01, base: 32'h55,    pct: 100, junk: 1'b0, expBeats: 1, expLastRow: 0};
    vecs[5] = '{mask: 8'h83, base: 32'h1234,  pct: 60,  junk: 1'b0, expBeats: 3, expLastRow: 7};
    expC    = '{1, 2, 3, 3, 3};

    repeat (2) @(posedge clk);
    #1;
    checkVal("rstOutread", {31'd0, bus.outread}, 32'd0);
    checkVal("rstValid", {31'd0, bus.m_valid}, 32'd0);
    checkVal("rstLast", {31'd0, bus.m_last}, 32'd0);
    checkVal("rstData", bus.m_data, 32'd0);
    checkVal("rstRow", {29'd0, bus.m_row}, 32'd0);
    checkVal("rstBusy", {31'd0, busy}, 32'd0);
    checkVal("rstSnapCnt", {16'd0, snapCnt}, 32'd0);
    rst = 1'b0;

    // Two-bit counter must saturate at 3.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      busC.rvalid_in = 8'h01;
      @(posedge clk);
      #1;
      busC.rvalid_in = '0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("satCnt", {30'd0, snapCntC}, 32'(expC[k]));
    end

    for (int v = 0; v < 6; v++) begin
      startBeats = beatsSeen;
      applyStimulus(vecs[v].mask, vecs[v].base, vecs[v].pct, vecs[v].junk);
      checkVal("beatCount", 32'(beatsSeen - startBeats), 32'(vecs[v].expBeats));
      checkVal("lastRow", 32'(lastRowSeen), 32'(vecs[v].expLastRow));
    end

    // Reset in the middle of a drain discards the remaining beats.
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) bus.rdata_in[r] = 32'd500 + 32'(r);
    bus.rvalid_in = 8'hFF;
    bus.m_ready   = 1'b1;
    pushExpected(8'hFF, 32'd500);
    startBeats = beatsSeen;
    @(posedge clk);
    #1;
    bus.rvalid_in = '0;
    n = 0;
    while ((beatsSeen - startBeats) < 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkVal("midBeats", 32'(beatsSeen - startBeats), 32'd3);
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
    checkVal("midRstOutread", {31'd0, bus.outread}, 32'd0);
    checkVal("midRstValid", {31'd0, bus.m_valid}, 32'd0);
    checkVal("midRstLast", {31'd0, bus.m_last}, 32'd0);
    checkVal("midRstData", bus.m_data, 32'd0);
    checkVal("midRstRow", {29'd0, bus.m_row}, 32'd0);
    checkVal("midRstBusy", {31'd0, busy}, 32'd0);
    checkVal("midRstSnapCnt", {16'd0, snapCnt}, 32'd0);
    expQ.delete();
    snapExp = 0;
    rst = 1'b0;
    applyStimulus(8'hFF, 32'd600, 100, 1'b0);

    // Back-to-back single-row snapshots with rvalid_in held high throughout.
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) bus.rdata_in[r] = 32'd700 + 32'(r);
    bus.rvalid_in = 8'h10;
    bus.m_ready   = 1'b1;
    pushExpected(8'h10, 32'd700);
    pushExpected(8'h10, 32'd700);
    snapExp += 2;
    @(posedge clk);
    #1;
    checkVal("b2bFirstAck", {31'd0, bus.outread}, 32'd1);
    checkVal("b2bFirstLast", {31'd0, bus.m_last}, 32'd1);
    @(posedge clk);
    #1;
    checkVal("b2bGapOutread", {31'd0, bus.outread}, 32'd0);
    checkVal("b2bGapBusy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    checkVal("b2bSecondAck", {31'd0, bus.outread}, 32'd1);
    bus.rvalid_in = '0;
    @(posedge clk);
    #1;
    checkVal("b2bDoneBusy", {31'd0, busy}, 32'd0);
    checkVal("b2bQueueEmpty", 32'(expQ.size()), 32'd0);
    checkVal("b2bSnapCnt", {16'd0, snapCnt}, 32'(snapExp));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout expected=completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
